// File: rtl/score_display.sv
// score_display: 16-bit kill count -> BCD (double-dabble) -> 4-digit muxed seven-segment display, saturating at 9999.
// Define SCORE_LZ_BLANK_EN to blank leading zeros (digit 0 always shown).
module score_display #(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] zombies_killed,
  output logic [3:0]  an,
  output logic [6:0]  ssd,
  output logic        dp,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;
  state_t r_state, w_next;
  logic [15:0] r_last_val, r_shreg, r_d;
  logic [19:0] r_bcd, w_bcd_adj;
  logic [3:0] r_iter, w_digit;
  logic [REFRESH_BITS-1:0] r_scan_cnt;
  logic [1:0] w_sel;
  logic [6:0] w_seg, r_ssd;
  logic [3:0] r_an;
  logic r_dp, w_change, w_blank;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_change = zombies_killed != r_last_val;
    w_next = r_state == IDLE  ? (w_change ? LOAD : IDLE) :
             r_state == LOAD  ? SHIFT :
             r_state == SHIFT ? (r_iter == 4'd15 ? COMMIT : SHIFT) : IDLE;
  end
  always_comb busy = r_state != IDLE;
  for (genvar i = 0; i < 5; i++) begin : g_adj
    assign w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] >= 4'd5 ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_last_val <= '0;
      r_shreg    <= '0;
      r_bcd      <= '0;
      r_iter     <= '0;
      r_d        <= '0;
    end else begin
      if (r_state == IDLE && w_change) r_last_val <= zombies_killed;
      if (r_state == LOAD) begin
        r_bcd   <= '0;
        r_shreg <= r_last_val;
        r_iter  <= '0;
      end
      if (r_state == SHIFT) begin
        {r_bcd, r_shreg} <= {w_bcd_adj, r_shreg} << 1;
        r_iter <= r_iter + 4'd1;
      end
      // a nonzero ten-thousands digit means the score exceeds the display range
      if (r_state == COMMIT) r_d <= r_bcd[19:16] != 4'd0 ? 16'h9999 : r_bcd[15:0];
    end
  always_comb begin
    w_sel   = r_scan_cnt[REFRESH_BITS-1 -: 2];
    w_digit = r_d[4*w_sel +: 4];
  end
`ifdef SCORE_LZ_BLANK_EN
  always_comb w_blank = w_sel == 2'd3 ? r_d[15:12] == 4'd0 :
                        w_sel == 2'd2 ? r_d[15:8] == 8'd0 :
                        w_sel == 2'd1 ? r_d[15:4] == 12'd0 : 1'b0;
`else
  always_comb w_blank = 1'b0;
`endif
  always_comb
    case (w_digit)
      4'd0:    w_seg = 7'b0000001;
      4'd1:    w_seg = 7'b1001111;
      4'd2:    w_seg = 7'b0010010;
      4'd3:    w_seg = 7'b0000110;
      4'd4:    w_seg = 7'b1001100;
      4'd5:    w_seg = 7'b0100100;
      4'd6:    w_seg = 7'b0100000;
      4'd7:    w_seg = 7'b0001111;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0000100;
      default: w_seg = 7'b1111111;
    endcase
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_scan_cnt <= '0;
      r_an       <= 4'b1111;
      r_ssd      <= 7'b1111111;
      r_dp       <= 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + REFRESH_BITS'(1);
      r_an       <= ~(4'b0001 << w_sel);
      r_ssd      <= w_blank ? 7'b1111111 : w_seg;
      r_dp       <= 1'b1;
    end
  assign an  = r_an;
  assign ssd = r_ssd;
  assign dp  = r_dp;
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: scoreboard bench; a busy-tracker flags each commit and a collector checks one full scan against queued BCD.
module tb_score_display;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] zk = 16'd0;
  logic [3:0] an;
  logic [6:0] ssd;
  logic dp, busy;
  int checks = 0, failures = 0, done_cnt = 0, pend = 0;
  logic [15:0] exp_q[$];

  score_display #(.REFRESH_BITS(4)) dut (
    .clk(clk), .reset(reset), .zombies_killed(zk),
    .an(an), .ssd(ssd), .dp(dp), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] bcd, input int k);
    logic [3:0] dig;
    dig = bcd[4*k +: 4];
`ifdef SCORE_LZ_BLANK_EN
    if (k > 0 && (bcd >> (4*k)) == 16'd0) return 7'b1111111;
`endif
    return seg(dig);
  endfunction

  function automatic int an_idx(input logic [3:0] a);
    return a == 4'b1110 ? 0 : a == 4'b1101 ? 1 : a == 4'b1011 ? 2 : a == 4'b0111 ? 3 : -1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_an", an, 4'b1111);
    check("rst_ssd", ssd, 7'b1111111);
    check("rst_dp", dp, 1'b1);
    check("rst_busy", busy, 1'b0);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("commit_timeout", done_cnt >= target, 1'b1);
  endtask

  task automatic run_conv(input logic [15:0] v, input logic [15:0] bcd);
    int target;
    target = done_cnt + 1;
    @(negedge clk);
    zk = v;
    exp_q.push_back(bcd);
    wait_done(target);
  endtask

  initial begin : tracker
    logic pb;
    int run;
    pb = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        pb = 1'b0;
        run = 0;
      end else if (busy) begin
        pb = 1'b1;
        run++;
      end else if (pb) begin
        pb = 1'b0;
        check("busy_len", run, 18);
        run = 0;
        pend++;
      end
    end
  end

  initial begin : collector
    logic [15:0] e;
    int k;
    forever begin
      wait (pend > 0);
      pend--;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_commit got=commit want=none t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        for (int s = 0; s < 16; s++) begin
          @(negedge clk);
          k = an_idx(an);
          if (k < 0) begin
            checks++;
            failures++;
            $display("FAIL scan_an got=%b want=one-low t=%0t", an, $time);
          end else check($sformatf("digit%0d_of_%h", k, e), ssd, exp_seg(e, k));
        end
        check("dp_off", dp, 1'b1);
      end
      done_cnt++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0] ea;
    int target, k;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    // idle with input 0: scan walks all anodes and wraps, busy never rises
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ea = ~(4'b0001 << ((i / 4) % 4));
      check("scan_an", an, ea);
      check("zero_seg", ssd, exp_seg(16'h0000, (i / 4) % 4));
      check("idle_busy", busy, 1'b0);
    end
    // 0 -> 1234 with exact latency checks
    target = done_cnt + 1;
    @(negedge clk);
    zk = 16'd1234;
    exp_q.push_back(16'h1234);
    @(negedge clk);
    check("busy_rise", busy, 1'b1);
    repeat (17) @(negedge clk);
    check("busy_last", busy, 1'b1);
    @(negedge clk);
    check("busy_fall", busy, 1'b0);
    k = an_idx(an);
    check("old_digit_n19", ssd, exp_seg(16'h0000, k < 0 ? 0 : k));
    @(negedge clk);
    k = an_idx(an);
    check("new_digit_n20", ssd, exp_seg(16'h1234, k < 0 ? 0 : k));
    wait_done(target);
    run_conv(16'd9999, 16'h9999);
    run_conv(16'd10000, 16'h9999);
    run_conv(16'd65535, 16'h9999);
    // change 5 -> 77 mid-conversion: both must commit in order
    target = done_cnt + 2;
    @(negedge clk);
    zk = 16'd5;
    exp_q.push_back(16'h0005);
    exp_q.push_back(16'h0077);
    repeat (3) @(negedge clk);
    zk = 16'd77;
    wait_done(target);
    // reset during SHIFT aborts, then 500 reconverts from scratch
    @(negedge clk);
    zk = 16'd500;
    repeat (5) @(negedge clk);
    check("shift_busy", busy, 1'b1);
    reset = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    target = done_cnt + 1;
    exp_q.push_back(16'h0500);
    @(negedge clk);
    check("post_rst_an", an, 4'b1110);
    check("post_rst_seg", ssd, 7'b0000001);
    check("post_rst_busy", busy, 1'b1);
    wait_done(target);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
